// File: rtl/ddfs_pkg.sv
// Shared DDFS definitions: default widths, midscale code, FSM states, dither LFSR constants,
// and the constant function that generates the quarter-wave sine table.
package ddfs_pkg;

    localparam int DEF_ACC_W  = 24;
    localparam int DEF_LUT_AW = 8;
    localparam int DEF_DAC_W  = 12;

    localparam logic [11:0] MIDSCALE = 12'h800;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Galois form of x^16+x^14+x^13+x^11+1 (right-shifting register)
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // pi scaled by 2^30
    localparam longint PI_Q30 = 64'sd3373259426;

    // round((2^(dac_w-1)-1) * sin(pi/2 * (idx+0.5) / 2^lut_aw)) via a Q30 Taylor series
    function automatic logic [15:0] sine_entry(input int idx, input int lut_aw, input int dac_w);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint amp;
        x    = (PI_Q30 * longint'(2 * idx + 1)) >>> (lut_aw + 2);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        amp = (longint'(1) <<< (dac_w - 1)) - longint'(1);
        return 16'((amp * sum + (longint'(1) <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine magnitude table with a registered (synchronous) read port.
module sine_quarter_rom
    import ddfs_pkg::*;
#(
    parameter int LUT_AW = DEF_LUT_AW,
    parameter int DAC_W  = DEF_DAC_W
) (
    input  logic              clk_in,
    input  logic [LUT_AW-1:0] addr,
    output logic [DAC_W-2:0]  mag
);

    localparam int MAG_W = DAC_W - 1;
    localparam int DEPTH = 2 ** LUT_AW;

    logic [MAG_W-1:0] rom [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign rom[gi] = MAG_W'(sine_entry(gi, LUT_AW, DAC_W));
    end

    always_ff @(posedge clk_in) begin
        mag <= rom[addr];
    end

endmodule

// File: rtl/ddfs_sample_engine.sv
// DDFS phase-to-amplitude engine: tick edge detect, phase accumulator, run/flush FSM, quarter-wave
// mirroring and offset-binary output. Define PHASE_DITHER_EN to add LFSR phase dither before truncation.
module ddfs_sample_engine
    import ddfs_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LUT_AW = DEF_LUT_AW,
    parameter int DAC_W  = DEF_DAC_W
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             enable,
    input  logic [ACC_W-1:0] phase_inc,
    input  logic [ACC_W-1:0] phase_ofs,
    output logic [DAC_W-1:0] dac_data,
    output logic             dac_valid,
    output logic             busy
);

    localparam int FRAC_W = ACC_W - 2 - LUT_AW;
    localparam int TOP_W  = LUT_AW + 2;
    localparam logic [DAC_W-1:0] MID_CODE = DAC_W'(MIDSCALE);

    state_t state_reg, state_next;
    logic             tick_d_reg;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic             v1_reg, v2_reg;
    logic             q1_reg;
    logic             step_accept;
    logic             flush_done;

    logic [ACC_W-1:0]  dither;
    logic [ACC_W-1:0]  p_sum;
    logic [TOP_W-1:0]  p_top;
    logic [1:0]        quad;
    logic [LUT_AW-1:0] addr_raw, rom_addr;
    logic [DAC_W-2:0]  rom_mag;
    logic [DAC_W-1:0]  mag_ext, sample;

    // A step dropped in the same cycle enable falls: require enable as well as RUN
    assign step_accept = tick_in & ~tick_d_reg & (state_reg == ST_RUN) & enable;
    assign busy        = (state_reg != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        flush_done = 1'b0;
        case (state_reg)
            ST_IDLE:  if (enable) state_next = ST_RUN;
            ST_RUN:   if (!enable) state_next = ST_FLUSH;
            ST_FLUSH: begin
                if (!v1_reg && !v2_reg) begin
                    flush_done = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_next = acc_reg;
        if (state_reg == ST_IDLE) begin
            acc_next = '0;
        end else if (step_accept) begin
            acc_next = acc_reg + phase_inc;
        end
    end

`ifdef PHASE_DITHER_EN
    logic [15:0] lfsr_reg, lfsr_next;

    always_comb begin
        lfsr_next = lfsr_reg >> 1;
        if (lfsr_reg[0]) begin
            lfsr_next = (lfsr_reg >> 1) ^ LFSR_POLY;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= LFSR_SEED;
        end else if (step_accept) begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign dither = ACC_W'(lfsr_reg[FRAC_W-1:0]);
`else
    assign dither = '0;
`endif

    // Only the quadrant and table-address bits of the offset phase matter after truncation
    assign p_sum    = acc_reg + phase_ofs + dither;
    assign p_top    = TOP_W'(p_sum >> FRAC_W);
    assign quad     = p_top[TOP_W-1 -: 2];
    assign addr_raw = p_top[LUT_AW-1:0];
    assign rom_addr = quad[0] ? ~addr_raw : addr_raw;

    sine_quarter_rom #(
        .LUT_AW (LUT_AW),
        .DAC_W  (DAC_W)
    ) u_rom (
        .clk_in (clk_in),
        .addr   (rom_addr),
        .mag    (rom_mag)
    );

    assign mag_ext = {1'b0, rom_mag};
    assign sample  = q1_reg ? (MID_CODE - DAC_W'(1) - mag_ext) : (MID_CODE + mag_ext);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            tick_d_reg <= 1'b0;
            acc_reg    <= '0;
            v1_reg     <= 1'b0;
            v2_reg     <= 1'b0;
            q1_reg     <= 1'b0;
            dac_data   <= MID_CODE;
            dac_valid  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tick_d_reg <= tick_in;
            acc_reg    <= acc_next;
            v1_reg     <= step_accept;
            v2_reg     <= v1_reg;
            q1_reg     <= quad[1];
            dac_valid  <= v2_reg;
            if (v2_reg) begin
                dac_data <= sample;
            end else if (flush_done) begin
                dac_data <= MID_CODE;
            end
        end
    end

endmodule
